// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, owner ids
// and the lowest usable memory latency.
package mem_port_arbiter_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int MIN_MEM_LAT = 1;

endpackage

// File: rtl/mem_port_arbiter_arb2_rr.sv
// Two-requester round-robin arbiter. Remembers the last winner and masks that
// winner's request for the one cycle after its access completes.
module arb2_rr
    import mem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_if,
    input  logic req_d,
    input  logic done,
    output logic gnt,
    output logic gnt_owner
);

    logic last_q;
    logic stale_q;
    logic elig_if;
    logic elig_d;

    // The requester just acked may still be holding its old request for a cycle.
    assign elig_if = req_if && !(stale_q && (last_q == OWN_IF));
    assign elig_d  = req_d  && !(stale_q && (last_q == OWN_D));
    assign gnt     = en && (elig_if || elig_d);

    always_comb begin
        gnt_owner = OWN_IF;
        if (elig_if && elig_d)
            gnt_owner = ~last_q;
        else if (elig_d)
            gnt_owner = OWN_D;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= OWN_IF;
            stale_q <= 1'b0;
        end else begin
            stale_q <= done;
            if (gnt)
                last_q <= gnt_owner;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store,
// sequencing each access with a fixed latency and parking the port on halt.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches the access
// ISSUE | memory strobe asserted for one cycle
// WAIT  | memory latency countdown (absent when MEM_LAT=1)
// DONE  | read data valid; ack pulsed to the owner
// HALT  | parked until reset
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_ack,
    output logic [DATA_W-1:0]     o_if_data,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_W-1:0]     i_d_addr,
    input  logic [DATA_W-1:0]     i_d_wdata,
    input  logic [DATA_W/8-1:0]   i_d_mask,
    output logic                  o_d_ack,
    output logic [DATA_W-1:0]     o_d_rdata,
    input  logic                  i_halt,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_mask,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic                  o_busy,
    output logic                  o_halted
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LAT - 1);

    if (MEM_LAT < MIN_MEM_LAT) begin : g_lat_chk
        $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] mask_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              halt_pend_q;
    logic              halt_now;
    logic              gnt;
    logic              gnt_owner;
    logic              done;

    assign halt_now = halt_pend_q | i_halt;
    assign done     = (state_q == ST_DONE);

    arb2_rr u_arb (
        .clk       (i_clk),
        .rst       (i_rst),
        .en        ((state_q == ST_IDLE) && !halt_now),
        .req_if    (i_if_req),
        .req_d     (i_d_req),
        .done      (done),
        .gnt       (gnt),
        .gnt_owner (gnt_owner)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (halt_now) state_d = ST_HALT;
                      else if (gnt) state_d = ST_ISSUE;
            ST_ISSUE: state_d = (WAIT_INIT != '0) ? ST_WAIT : ST_DONE;
            ST_WAIT:  if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;
            ST_DONE:  state_d = halt_now ? ST_HALT : ST_IDLE;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (i_halt)
                halt_pend_q <= 1'b1;
            if (gnt) begin
                owner_q <= gnt_owner;
                we_q    <= (gnt_owner == OWN_D) && i_d_we;
                addr_q  <= (gnt_owner == OWN_D) ? i_d_addr : i_if_addr;
                wdata_q <= (gnt_owner == OWN_D) ? i_d_wdata : '0;
                mask_q  <= (gnt_owner == OWN_D) ? i_d_mask : '0;
            end
            if (state_q == ST_ISSUE)
                cnt_q <= WAIT_INIT;
            else if ((state_q == ST_WAIT) && (cnt_q != '0))
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign o_mem_en    = (state_q == ST_ISSUE);
    assign o_mem_we    = o_mem_en && we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_mask  = mask_q;

    assign o_if_ack  = done && (owner_q == OWN_IF);
    assign o_d_ack   = done && (owner_q == OWN_D);
    assign o_if_data = o_if_ack ? i_mem_rdata : '0;
    assign o_d_rdata = (o_d_ack && !we_q) ? i_mem_rdata : '0;

    assign o_busy   = (state_q != ST_IDLE);
    assign o_halted = (state_q == ST_HALT);

endmodule
